bits_reassembler: RTL and testbench

BITS_REASSEMBLER -- requirements
Module: bits_reassembler

---
 rtl/bits_reassembler.sv | 179 +++++++++++++++++
 tb/tb_bits_reassembler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bits_reassembler.sv
// Rebuilds a WIDTH-bit word from a serial stream of (position, bit) pairs.
// Protocol violations, upstream error markers and mid-frame stalls latch a sticky error.
module bits_reassembler #(
    parameter int               WIDTH     = 32,
    parameter int               LOG_WIDTH = 5,
    parameter logic [WIDTH-1:0] ERRORCODE = 32'hDEADBEEF,
    parameter int               TIMEOUT   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_nd,
    output logic [WIDTH-1:0] out_data,
    output logic             out_nd,
    output logic             error,
    output logic [1:0]       err_cause
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [WIDTH-1:0]     TOP_POS = WIDTH'(WIDTH - 1);
    localparam logic [LOG_WIDTH-1:0] POS_MAX = LOG_WIDTH'(WIDTH - 1);
    localparam logic [CW-1:0]        IDLE_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXP_VAL,
        S_EXP_POS,
        S_ERR
    } state_t;

    state_t               r_state;
    logic [LOG_WIDTH-1:0] r_pos;
    logic [WIDTH-1:0]     r_shift;
    logic [CW-1:0]        r_idle;
    logic [WIDTH-1:0]     r_out_data;
    logic                 r_out_nd;
    logic                 r_error;
    logic [1:0]           r_cause;

    state_t               w_state_nxt;
    logic [1:0]           w_cause_nxt;
    logic [CW-1:0]        w_idle_nxt;
    logic                 w_start;
    logic                 w_store;
    logic                 w_done;
    logic                 w_enter_err;
    logic                 w_is_err;
    logic                 w_is_bit;
    logic                 w_pos_match;
    logic                 w_idle_hit;
    logic [WIDTH-1:0]     w_word;

    assign w_is_err    = (in_data == ERRORCODE);
    assign w_is_bit    = (in_data[WIDTH-1:1] == '0);
    assign w_pos_match = (in_data == {{(WIDTH-LOG_WIDTH){1'b0}}, r_pos});
    assign w_idle_hit  = (r_idle == IDLE_LAST);
    assign w_enter_err = (w_state_nxt == S_ERR) && (r_state != S_ERR);

    // Completed word: shift register with the final bit merged in.
    always_comb begin
        w_word        = r_shift;
        w_word[r_pos] = in_data[0];
    end

    // Next-state decode; error marker outranks sequence checks.
    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = 2'd0;
        w_idle_nxt  = '0;
        w_start     = 1'b0;
        w_store     = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (in_nd) begin
                    if (w_is_err) begin
                        w_state_nxt = S_ERR;
                        w_cause_nxt = 2'd1;
                    end else if (in_data == TOP_POS) begin
                        w_state_nxt = S_EXP_VAL;
                        w_start     = 1'b1;
                    end else begin
                        w_state_nxt = S_ERR;
                        w_cause_nxt = 2'd2;
                    end
                end
            end
            S_EXP_VAL: begin
                if (in_nd) begin
                    if (w_is_err) begin
                        w_state_nxt = S_ERR;
                        w_cause_nxt = 2'd1;
                    end else if (w_is_bit) begin
                        w_store = 1'b1;
                        if (r_pos == '0) begin
                            w_done      = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_EXP_POS;
                        end
                    end else begin
                        w_state_nxt = S_ERR;
                        w_cause_nxt = 2'd2;
                    end
                end else if (w_idle_hit) begin
                    w_state_nxt = S_ERR;
                    w_cause_nxt = 2'd3;
                end else begin
                    w_idle_nxt = r_idle + 1'b1;
                end
            end
            S_EXP_POS: begin
                if (in_nd) begin
                    if (w_is_err) begin
                        w_state_nxt = S_ERR;
                        w_cause_nxt = 2'd1;
                    end else if (w_pos_match) begin
                        w_state_nxt = S_EXP_VAL;
                    end else begin
                        w_state_nxt = S_ERR;
                        w_cause_nxt = 2'd2;
                    end
                end else if (w_idle_hit) begin
                    w_state_nxt = S_ERR;
                    w_cause_nxt = 2'd3;
                end else begin
                    w_idle_nxt = r_idle + 1'b1;
                end
            end
            S_ERR: begin
                w_state_nxt = S_ERR;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pos      <= '0;
            r_shift    <= '0;
            r_idle     <= '0;
            r_out_data <= '0;
            r_out_nd   <= 1'b0;
            r_error    <= 1'b0;
            r_cause    <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_idle   <= w_idle_nxt;
            r_out_nd <= w_done;
            if (w_start) begin
                r_shift <= '0;
                r_pos   <= POS_MAX;
            end
            if (w_store) begin
                r_shift[r_pos] <= in_data[0];
                if (r_pos != '0) begin
                    r_pos <= r_pos - 1'b1;
                end
            end
            if (w_done) begin
                r_out_data <= w_word;
            end
            if (w_enter_err) begin
                r_error <= 1'b1;
                r_cause <= w_cause_nxt;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_nd    = r_out_nd;
    assign error     = r_error;
    assign err_cause = r_cause;

endmodule

// File: tb/tb_bits_reassembler.sv
// Directed and randomized checks of bits_reassembler against frames built
// from known words; expected results follow from the word and the scenario.
module tb_bits_reassembler;

    logic        clk;
    logic        reset;
    logic [31:0] in_data;
    logic        in_nd;
    logic [31:0] out_data;
    logic        out_nd;
    logic        error;
    logic [1:0]  err_cause;

    int checks;
    int errors;
    int pulses;
    int cyc;
    int pcyc[$];

    localparam logic [31:0] ECODE = 32'hDEADBEEF;

    bits_reassembler dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_nd     (in_nd),
        .out_data  (out_data),
        .out_nd    (out_nd),
        .error     (error),
        .err_cause (err_cause)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_nd === 1'b1) begin
            pulses <= pulses + 1;
            pcyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        in_nd = 1'b0;
        repeat (n) begin
            in_data = $urandom;
            tick();
        end
    endtask

    task automatic put(input logic [31:0] w);
        in_data = w;
        in_nd   = 1'b1;
        tick();
        in_nd   = 1'b0;
        in_data = $urandom;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_nd = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Word k of a frame: even k is a position, odd k the bit at it.
    task automatic words(input logic [31:0] w, input int a, input int b,
                         input int gmax);
        for (int k = a; k < b; k++) begin
            int p;
            p = 31 - k / 2;
            if (k % 2 == 0) put(32'(p));
            else put({31'd0, w[p]});
            if (gmax > 0 && k != 63) gap($urandom_range(gmax, 0));
        end
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] w2;
        int base;
        checks = 0;
        errors = 0;
        pulses = 0;
        cyc = 0;
        clk = 1'b0;
        reset = 1'b1;
        in_nd = 1'b0;
        in_data = '0;
        repeat (3) tick();
        chk("rst_data", out_data, 32'd0);
        chk("rst_nd", {31'd0, out_nd}, 32'd0);
        chk("rst_err", {31'd0, error}, 32'd0);
        chk("rst_cause", {30'd0, err_cause}, 32'd0);
        reset = 1'b0;
        tick();

        words(32'hA5A5_0F0F, 0, 64, 0);
        chk("a5_nd", {31'd0, out_nd}, 32'd1);
        chk("a5_data", out_data, 32'hA5A5_0F0F);
        chk("a5_err", {31'd0, error}, 32'd0);
        tick();
        chk("a5_nd_drop", {31'd0, out_nd}, 32'd0);
        chk("a5_hold", out_data, 32'hA5A5_0F0F);
        gap(3);

        base = pcyc.size();
        words(32'h0000_0001, 0, 64, 0);
        chk("b2b1_nd", {31'd0, out_nd}, 32'd1);
        chk("b2b1_data", out_data, 32'h0000_0001);
        words(32'hFFFF_FFFF, 0, 64, 0);
        chk("b2b2_nd", {31'd0, out_nd}, 32'd1);
        chk("b2b2_data", out_data, 32'hFFFF_FFFF);
        gap(2);
        chk("b2b_cnt", 32'(pcyc.size() - base), 32'd2);
        if (pcyc.size() >= base + 2)
            chk("b2b_space", 32'(pcyc[base+1] - pcyc[base]), 32'd64);

        for (int i = 0; i < 6; i++) begin
            w = $urandom;
            base = pulses;
            words(w, 0, 64, (i % 2 == 0) ? 15 : 3);
            chk("rnd_nd", {31'd0, out_nd}, 32'd1);
            chk("rnd_data", out_data, w);
            chk("rnd_err", {31'd0, error}, 32'd0);
            gap($urandom_range(2, 0) + 1);
            chk("rnd_cnt", 32'(pulses - base), 32'd1);
        end

        do_reset();
        put(32'd31);
        put(32'd1);
        put(32'd29);
        chk("seq_err", {31'd0, error}, 32'd1);
        chk("seq_cause", {30'd0, err_cause}, 32'd2);
        base = pulses;
        words($urandom, 0, 64, 0);
        gap(2);
        chk("seq_nopulse", 32'(pulses - base), 32'd0);
        chk("seq_cause_hold", {30'd0, err_cause}, 32'd2);

        do_reset();
        chk("clr_err", {31'd0, error}, 32'd0);
        w = $urandom;
        words(w, 0, 10, 0);
        put(ECODE);
        chk("ec_err", {31'd0, error}, 32'd1);
        chk("ec_cause", {30'd0, err_cause}, 32'd1);
        base = pulses;
        words($urandom, 0, 64, 0);
        gap(2);
        chk("ec_nopulse", 32'(pulses - base), 32'd0);
        chk("ec_cause_hold", {30'd0, err_cause}, 32'd1);

        do_reset();
        words($urandom, 0, 10, 0);
        gap(15);
        chk("to15_err", {31'd0, error}, 32'd0);
        gap(1);
        chk("to16_err", {31'd0, error}, 32'd1);
        chk("to16_cause", {30'd0, err_cause}, 32'd3);

        do_reset();
        w = $urandom;
        words(w, 0, 10, 0);
        gap(15);
        words(w, 10, 64, 0);
        chk("st15_nd", {31'd0, out_nd}, 32'd1);
        chk("st15_data", out_data, w);
        chk("st15_err", {31'd0, error}, 32'd0);
        gap(2);

        do_reset();
        base = pulses;
        words($urandom, 0, 20, 0);
        gap(2);
        chk("part_nopulse", 32'(pulses - base), 32'd0);
        do_reset();
        w2 = $urandom;
        words(w2, 0, 64, 0);
        chk("mid_rst_data", out_data, w2);
        chk("mid_rst_err", {31'd0, error}, 32'd0);
        gap(2);
        chk("mid_rst_cnt", 32'(pulses - base), 32'd1);

        reset = 1'b1;
        in_data = 32'd31;
        in_nd = 1'b1;
        tick();
        reset = 1'b0;
        in_nd = 1'b0;
        w = $urandom;
        words(w, 0, 64, 0);
        chk("rst_pri_data", out_data, w);
        chk("rst_pri_err", {31'd0, error}, 32'd0);

        do_reset();
        put(32'd5);
        chk("idle_seq_cause", {30'd0, err_cause}, 32'd2);
        do_reset();
        put(ECODE);
        chk("idle_ec_cause", {30'd0, err_cause}, 32'd1);
        chk("idle_ec_err", {31'd0, error}, 32'd1);

        gap(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
